// File: rtl/gnrl_cdc_tx.sv
// Source-side transmitter for a four-phase req/ack clock-domain crossing.
// Holds one word on o_data while o_req is high, then waits for the synchronized ack to rise and fall.
module gnrl_cdc_tx #(
  parameter int unsigned   DW            = 8,
  parameter logic [DW-1:0] DEF_VAL       = '0,
  parameter int unsigned   SYNC_PIPE_NUM = 2,
  parameter int unsigned   TMO_CYC       = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_rdy,
  output logic          o_req,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  output logic          o_done,
  output logic          o_tmo
);

  localparam int unsigned CW      = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO_LIM = CW'(TMO_CYC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  state_t                   state;
  state_t                   state_d;
  logic [SYNC_PIPE_NUM-1:0] sync_q;
  logic                     ack_s;
  logic                     req_d;
  logic                     done_d;
  logic                     tmo_d;
  logic [DW-1:0]            data_d;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_d;

  // Ack synchronizer; the FSM only ever looks at the last stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_PIPE_NUM-2:0], i_ack};
    end
  end

  assign ack_s = sync_q[SYNC_PIPE_NUM-1];

  // A stale ack (e.g. still high after a reset) must fall before a new word is taken.
  assign o_rdy = (state == IDLE) & ~ack_s;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_req  <= 1'b0;
      o_data <= DEF_VAL;
      o_done <= 1'b0;
      o_tmo  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      o_req  <= req_d;
      o_data <= data_d;
      o_done <= done_d;
      o_tmo  <= tmo_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    req_d   = o_req;
    data_d  = o_data;
    done_d  = 1'b0;
    tmo_d   = o_tmo;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (i_vld && o_rdy) begin
          data_d  = i_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = REL;
        end else if (TMO_CYC != 0) begin
          // Watchdog only flags; the transfer keeps waiting for ack.
          if (cnt != TMO_LIM) begin
            cnt_d = cnt + CW'(1);
          end
          if (cnt_d == TMO_LIM) begin
            tmo_d = 1'b1;
          end
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gnrl_cdc_tx.sv
// Directed and randomized self-checking bench for gnrl_cdc_tx (DW=8, sync depth 2, watchdog 16).
module tb_gnrl_cdc_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld;
  logic [7:0] din;
  logic       rdy;
  logic       req;
  logic [7:0] dout;
  logic       ack;
  logic       done;
  logic       tmo;

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   mode     = 0;  // 0 manual ack, 1 zero-delay loopback, 2 random-delay responder
  logic ack_man  = 1'b0;
  logic ack_rnd  = 1'b0;
  int   rdly     = 0;

  always #5 clk = ~clk;

  assign ack = (mode == 1) ? req : (mode == 2) ? ack_rnd : ack_man;

  gnrl_cdc_tx #(
    .DW(8),
    .DEF_VAL(8'hA5),
    .SYNC_PIPE_NUM(2),
    .TMO_CYC(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_vld(vld),
    .i_data(din),
    .o_rdy(rdy),
    .o_req(req),
    .o_data(dout),
    .i_ack(ack),
    .o_done(done),
    .o_tmo(tmo)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  // Destination model: follows o_req after 0..20 cycles.
  always @(posedge clk) begin
    if (mode != 2) begin
      ack_rnd <= 1'b0;
      rdly    <= 0;
    end else if (ack_rnd != req) begin
      if (rdly == 0) begin
        ack_rnd <= req;
        rdly    <= int'($urandom_range(0, 20));
      end else begin
        rdly <= rdly - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sb[$];

  task automatic take_done();
    if (done) begin
      if (sb.size() == 0) check("spurious_done", 32'(1), 32'(0));
      else                check("done_word", 32'(dout), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         nacc;
    int         last;
    int         d0;
    logic       acc;
    logic       seen;
    logic       pend;
    logic       pq;
    logic [7:0] pd;
    logic [7:0] word;

    rst_n = 1'b0;
    vld   = 1'b0;
    din   = 8'h00;

    // Reset values
    step();
    step();
    check("rst_data", 32'(dout), 32'(8'hA5));
    check("rst_req", 32'(req), 32'(0));
    check("rst_rdy", 32'(rdy), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_tmo", 32'(tmo), 32'(0));
    rst_n = 1'b1;
    step();

    // Loopback single word
    mode = 1;
    vld  = 1'b1;
    din  = 8'h3C;
    step();  // T0
    vld = 1'b0;
    din = 8'h00;
    check("lb_req_t0", 32'(req), 32'(1));
    check("lb_data_t0", 32'(dout), 32'(8'h3C));
    check("lb_rdy_t0", 32'(rdy), 32'(0));
    step();
    check("lb_req_t1", 32'(req), 32'(1));
    step();
    check("lb_req_t2", 32'(req), 32'(1));
    check("lb_done_t2", 32'(done), 32'(0));
    step();
    check("lb_req_t3", 32'(req), 32'(0));
    check("lb_done_t3", 32'(done), 32'(1));
    check("lb_data_t3", 32'(dout), 32'(8'h3C));
    step();
    check("lb_done_t4", 32'(done), 32'(0));
    step();
    check("lb_rdy_t5", 32'(rdy), 32'(0));
    step();
    check("lb_rdy_t6", 32'(rdy), 32'(1));

    // Loopback back-to-back, words 1..5
    word = 8'd1;
    din  = word;
    vld  = 1'b1;
    nacc = 0;
    last = 0;
    d0   = done_cnt;
    for (int c = 0; c < 80 && nacc < 5; c++) begin
      acc = vld & rdy;
      step();
      if (acc) begin
        check("b2b_data", 32'(dout), 32'(word));
        if (nacc > 0) check("b2b_gap", 32'(c - last), 32'(7));
        last = c;
        nacc++;
        word = word + 8'd1;
        din  = word;
        if (nacc == 5) vld = 1'b0;
      end
    end
    check("b2b_accepts", 32'(nacc), 32'(5));
    repeat (8) step();
    check("b2b_dones", 32'(done_cnt - d0), 32'(5));

    // Stalled ack and watchdog
    mode    = 0;
    ack_man = 1'b0;
    check("stall_rdy_pre", 32'(rdy), 32'(1));
    vld = 1'b1;
    din = 8'h77;
    step();  // T0
    vld = 1'b0;
    repeat (15) step();
    check("stall_tmo_t15", 32'(tmo), 32'(0));
    check("stall_req_t15", 32'(req), 32'(1));
    step();
    check("stall_tmo_t16", 32'(tmo), 32'(1));
    repeat (10) step();
    check("stall_tmo_hold", 32'(tmo), 32'(1));
    check("stall_req_hold", 32'(req), 32'(1));
    check("stall_rdy_hold", 32'(rdy), 32'(0));
    check("stall_data_hold", 32'(dout), 32'(8'h77));
    ack_man = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (done) seen = 1'b1;
    end
    check("stall_done", 32'(seen), 32'(1));
    check("stall_req_drop", 32'(req), 32'(0));
    check("stall_tmo_kept", 32'(tmo), 32'(1));
    ack_man = 1'b0;
    repeat (3) step();
    check("stall_rdy_back", 32'(rdy), 32'(1));

    // Reset mid-REQ with ack held high
    vld = 1'b1;
    din = 8'h55;
    step();
    vld     = 1'b0;
    ack_man = 1'b1;
    step();
    rst_n = 1'b0;
    step();  // reset edge
    rst_n = 1'b1;
    d0    = done_cnt;
    check("mid_req", 32'(req), 32'(0));
    check("mid_tmo", 32'(tmo), 32'(0));
    check("mid_data", 32'(dout), 32'(8'hA5));
    step();
    check("mid_rdy_r1", 32'(rdy), 32'(1));
    step();
    check("mid_rdy_r2", 32'(rdy), 32'(0));
    repeat (3) step();
    check("mid_rdy_stale", 32'(rdy), 32'(0));
    ack_man = 1'b0;
    step();
    check("mid_rdy_f1", 32'(rdy), 32'(0));
    step();
    check("mid_rdy_f2", 32'(rdy), 32'(1));
    check("mid_no_done", 32'(done_cnt - d0), 32'(0));

    // Random vld and random ack delays against a scoreboard
    mode = 2;
    pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        vld = 1'($urandom_range(0, 1));
        din = 8'($urandom);
      end
      acc = vld & rdy;
      if (acc) sb.push_back(din);
      pq = req;
      pd = dout;
      step();
      pend = vld & ~acc;
      if (pq && req) check("rnd_hold", 32'(dout), 32'(pd));
      take_done();
    end
    vld = 1'b0;
    for (int c = 0; c < 150 && sb.size() != 0; c++) begin
      step();
      take_done();
    end
    check("rnd_drain", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
